// File: rtl/stream_decoder_pkg.sv
// Shared stream-format constants, FSM/op encodings and colour hash used by
// both the decoder and the matching encoder.
package stream_decoder_pkg;

   localparam int NUM_PIXELS_DEFAULT = 307200;   // 640x480 frame
   localparam int ADDR_W_DEFAULT     = 19;

   // Byte-level tags of the encoded stream
   localparam logic [7:0] TAG_END     = 8'hFF;
   localparam logic [7:0] TAG_LITERAL = 8'hFE;
   localparam logic [1:0] TAG_INDEX   = 2'b00;
   localparam logic [1:0] TAG_DIFF    = 2'b01;
   localparam logic [1:0] TAG_LUMA    = 2'b10;
   localparam logic [1:0] TAG_RUN     = 2'b11;

   // Biases subtracted from the unsigned delta fields
   localparam logic [7:0] DIFF_BIAS    = 8'd2;
   localparam logic [7:0] LUMA_G_BIAS  = 8'd4;
   localparam logic [7:0] LUMA_RB_BIAS = 8'd8;

   // Colour index table geometry
   localparam int IDX_W       = 6;
   localparam int TABLE_DEPTH = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_DISPATCH,
      ST_FETCH2,
      ST_WAIT2,
      ST_EMIT,
      ST_DONE
   } state_t;

   typedef enum logic [2:0] {
      OP_LITERAL,
      OP_RUN,
      OP_INDEX,
      OP_DIFF,
      OP_LUMA
   } op_t;

   // Table slot of an RGB332 pixel: (r*3 + g*5 + b*7) mod 64
   function automatic logic [IDX_W-1:0] color_hash(input logic [7:0] px);
      logic [7:0] sum;
      sum = ({5'b0, px[7:5]} * 8'd3) + ({5'b0, px[4:2]} * 8'd5) + ({6'b0, px[1:0]} * 8'd7);
      return sum[IDX_W-1:0];
   endfunction

   // Add per-channel deltas modulo channel width (3/3/2 bits), no saturation
   function automatic logic [7:0] apply_delta(input logic [7:0] px, input logic [7:0] dr,
                                              input logic [7:0] dg, input logic [7:0] db);
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
      r = px[7:5] + dr[2:0];
      g = px[4:2] + dg[2:0];
      b = px[1:0] + db[1:0];
      return {r, g, b};
   endfunction

endpackage

// File: rtl/stream_decoder_if.sv
// Bus bundle of the stream decoder: encoded-stream BRAM read port, frame-buffer
// write port and frame control/status.
//
// Handshake: rd_enable is a one-cycle read strobe for rd_addr; the memory
// returns the byte on rd_data in the following cycle and holds it until the
// next strobe. wr_enable qualifies wr_addr/wr_data for exactly one pixel per
// asserted cycle; the frame buffer always accepts (no backpressure). start is
// a level sampled only while the decoder is idle or done.
interface stream_decoder_if
   import stream_decoder_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT
);
   logic              start;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_enable;
   logic [7:0]        rd_data;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              wr_enable;
   logic              done;
   logic              error;

   // Decoder side
   modport master (
      input  start, rd_data,
      output rd_addr, rd_enable, wr_addr, wr_data, wr_enable, done, error
   );

   // Memory / controller side
   modport slave (
      output start, rd_data,
      input  rd_addr, rd_enable, wr_addr, wr_data, wr_enable, done, error
   );
endinterface

// File: rtl/stream_decoder_color_index_table.sv
// 64-entry recently-seen colour table: one write port, combinational read
// port returning 8'h00 for slots not written since the last clear.
module color_index_table
   import stream_decoder_pkg::*;
(
   input  logic             clk,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [7:0]       wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [7:0]       rd_data
);

   logic [7:0]             mem [TABLE_DEPTH];
   logic [TABLE_DEPTH-1:0] valid;

   // Colour storage; stale contents are masked by the valid bits
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // Valid bits: whole table invalidated in a single cycle
   always_ff @(posedge clk) begin
      if (clear) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   assign rd_data = valid[rd_idx] ? mem[rd_idx] : 8'h00;

endmodule

// File: rtl/stream_decoder.sv
// Decodes a QOI-like RGB332 byte stream from a BRAM into a frame buffer,
// one pixel per EMIT cycle, flagging malformed or truncated streams.
module stream_decoder
   import stream_decoder_pkg::*;
#(
   parameter int NUM_PIXELS = NUM_PIXELS_DEFAULT,
   parameter int ADDR_W     = ADDR_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   stream_decoder_if.master   bus,
   output state_t             fsm_state
);

   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_t            state;
   state_t            next_state;
   logic [ADDR_W-1:0] rd_addr_q;
   logic              rd_exhausted;   // byte at ADDR_MAX already read
   logic [ADDR_W-1:0] pix_cnt;
   logic [5:0]        run_left;       // RUN copies still to emit after this one
   op_t               op;
   op_t               dec_op;
   logic [5:0]        operand;        // low bits of the opcode byte
   logic [7:0]        prev;
   logic              error_q;
   logic              set_error;
   logic              frame_start;
   logic              emit;
   logic              last_pix;
   logic [7:0]        pixel;
   logic [7:0]        tbl_data;
   logic [7:0]        dr;
   logic [7:0]        dg;
   logic [7:0]        db;

   assign frame_start = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;
   assign emit        = (state == ST_EMIT);
   assign last_pix    = (pix_cnt == LAST_PIX);

   // Classify the opcode byte presented during DISPATCH
   always_comb begin
      dec_op = OP_LITERAL;
      if (bus.rd_data != TAG_LITERAL) begin
         unique case (bus.rd_data[7:6])
            TAG_INDEX: dec_op = OP_INDEX;
            TAG_DIFF:  dec_op = OP_DIFF;
            TAG_LUMA:  dec_op = OP_LUMA;
            default:   dec_op = OP_RUN;
         endcase
      end
   end

   // Pixel produced in EMIT; LITERAL and LUMA take their second byte from rd_data
   always_comb begin
      pixel = prev;
      dr    = '0;
      dg    = '0;
      db    = '0;
      unique case (op)
         OP_LITERAL: pixel = bus.rd_data;
         OP_INDEX:   pixel = tbl_data;
         OP_DIFF: begin
            dr    = {6'b0, operand[5:4]} - DIFF_BIAS;
            dg    = {6'b0, operand[3:2]} - DIFF_BIAS;
            db    = {6'b0, operand[1:0]} - DIFF_BIAS;
            pixel = apply_delta(prev, dr, dg, db);
         end
         OP_LUMA: begin
            dg    = {5'b0, operand[2:0]} - LUMA_G_BIAS;
            dr    = dg + {4'b0, bus.rd_data[7:4]} - LUMA_RB_BIAS;
            db    = dg + {4'b0, bus.rd_data[3:0]} - LUMA_RB_BIAS;
            pixel = apply_delta(prev, dr, dg, db);
         end
         default:    pixel = prev;
      endcase
   end

   // Next-state logic and error detection
   always_comb begin
      next_state = state;
      set_error  = 1'b0;
      unique case (state)
         ST_IDLE:  if (bus.start) next_state = ST_FETCH;
         ST_FETCH: next_state = ST_WAIT;
         ST_WAIT:  next_state = ST_DISPATCH;
         ST_DISPATCH: begin
            if (bus.rd_data == TAG_END) begin
               // END always arrives early: a complete frame never reaches DISPATCH again
               next_state = ST_DONE;
               set_error  = 1'b1;
            end else if ((dec_op == OP_LITERAL) || (dec_op == OP_LUMA)) begin
               if (rd_exhausted) begin
                  next_state = ST_DONE;
                  set_error  = 1'b1;
               end else begin
                  next_state = ST_FETCH2;
               end
            end else begin
               next_state = ST_EMIT;
            end
         end
         ST_FETCH2: next_state = ST_WAIT2;
         ST_WAIT2:  next_state = ST_EMIT;
         ST_EMIT: begin
            if (last_pix) begin
               next_state = ST_DONE;
               set_error  = (run_left != 6'd0);   // RUN truncated at frame end
            end else if (run_left != 6'd0) begin
               next_state = ST_EMIT;
            end else if (rd_exhausted) begin
               next_state = ST_DONE;
               set_error  = 1'b1;
            end else begin
               next_state = ST_FETCH;
            end
         end
         ST_DONE:  if (bus.start) next_state = ST_FETCH;
         default:  next_state = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Datapath registers: read pointer, pixel counter, opcode latch, prev pixel, error
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr_q    <= '0;
         rd_exhausted <= 1'b0;
         pix_cnt      <= '0;
         run_left     <= '0;
         op           <= OP_LITERAL;
         operand      <= '0;
         prev         <= 8'h00;
         error_q      <= 1'b0;
      end else if (frame_start) begin
         rd_addr_q    <= '0;
         rd_exhausted <= 1'b0;
         pix_cnt      <= '0;
         run_left     <= '0;
         prev         <= 8'h00;
         error_q      <= 1'b0;
      end else begin
         if (set_error) begin
            error_q <= 1'b1;
         end
         if ((state == ST_FETCH) || (state == ST_FETCH2)) begin
            // Pointer parks at the top address instead of wrapping
            if (rd_addr_q == ADDR_MAX) begin
               rd_exhausted <= 1'b1;
            end else begin
               rd_addr_q <= rd_addr_q + 1'b1;
            end
         end
         if (state == ST_DISPATCH) begin
            op       <= dec_op;
            operand  <= bus.rd_data[5:0];
            run_left <= (dec_op == OP_RUN) ? bus.rd_data[5:0] : 6'd0;
         end
         if (emit) begin
            prev    <= pixel;
            pix_cnt <= pix_cnt + 1'b1;
            if (run_left != 6'd0) begin
               run_left <= run_left - 6'd1;
            end
         end
      end
   end

   color_index_table u_index (
      .clk     (clk),
      .clear   (rst | frame_start),
      .wr_en   (emit),
      .wr_idx  (color_hash(pixel)),
      .wr_data (pixel),
      .rd_idx  (operand),
      .rd_data (tbl_data)
   );

   assign bus.rd_addr   = rd_addr_q;
   assign bus.rd_enable = (state == ST_FETCH) || (state == ST_FETCH2);
   assign bus.wr_addr   = pix_cnt;
   assign bus.wr_data   = emit ? pixel : 8'h00;
   assign bus.wr_enable = emit;
   assign bus.done      = (state == ST_DONE);
   assign bus.error     = error_q;
   assign fsm_state     = state;

endmodule

// File: tb/tb_stream_decoder.sv
// Directed bench for stream_decoder with NUM_PIXELS=4: a BRAM model feeds
// hand-encoded streams, a monitor checks every frame-buffer write against
// an expected queue, and frame-level status is checked after each frame.
module tb_stream_decoder;
   import stream_decoder_pkg::*;

   localparam int ADDR_W = 19;
   localparam int NPIX   = 4;

   logic   clk;
   logic   rst;
   state_t fsm_state;
   logic [7:0] mem [64];

   logic [ADDR_W+7:0] exp_q[$];
   int checks;
   int errors;
   int wr_count;

   stream_decoder_if #(.ADDR_W(ADDR_W)) bus ();

   stream_decoder #(.NUM_PIXELS(NPIX), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .fsm_state (fsm_state)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Encoded-stream BRAM model: registered read, output held between strobes
   always @(posedge clk) begin
      if (bus.rd_enable) bus.rd_data <= mem[bus.rd_addr[5:0]];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Monitor: every write must match the head of the expected queue
   always @(negedge clk) begin
      logic [ADDR_W+7:0] exp;
      if (bus.wr_enable === 1'b1) begin
         wr_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%0d data=%h, no write required",
                     bus.wr_addr, bus.wr_data);
         end else begin
            exp = exp_q.pop_front();
            if ({bus.wr_addr, bus.wr_data} !== exp) begin
               errors++;
               $display("FAIL pixel_write: got addr=%0d data=%h, required addr=%0d data=%h",
                        bus.wr_addr, bus.wr_data, exp[ADDR_W+7:8], exp[7:0]);
            end
         end
      end
   end

   task automatic push_px(input int addr, input logic [7:0] px);
      exp_q.push_back({addr[ADDR_W-1:0], px});
   endtask

   // Stream bytes from the MSB end of s; rest of memory reads as END
   task automatic load_stream(input logic [63:0] s);
      for (int i = 0; i < 64; i++) mem[i] = 8'hFF;
      for (int i = 0; i < 8; i++) mem[i] = s[63-8*i -: 8];
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic run_frame(input string name, input logic [63:0] s, input logic exp_err,
                            input int exp_writes, input int exp_rd_addr, input logic poke_start);
      logic [ADDR_W-1:0] rd_at_done;
      load_stream(s);
      wr_count = 0;
      pulse_start();
      check({name, "_error_cleared"}, 32'(bus.error), 32'(1'b0));
      if (poke_start) begin
         // start held high mid-frame must not restart decoding
         repeat (3) @(negedge clk);
         bus.start = 1'b1;
         repeat (2) @(negedge clk);
         bus.start = 1'b0;
      end
      for (int i = 0; i < 400 && bus.done !== 1'b1; i++) @(negedge clk);
      check({name, "_done"}, 32'(bus.done), 32'(1'b1));
      check({name, "_error"}, 32'(bus.error), 32'(exp_err));
      check({name, "_writes"}, 32'(wr_count), 32'(exp_writes));
      check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
      check({name, "_rd_addr"}, 32'(bus.rd_addr), 32'(exp_rd_addr));
      rd_at_done = bus.rd_addr;
      repeat (4) @(negedge clk);
      check({name, "_hold_done"}, 32'(bus.done), 32'(1'b1));
      check({name, "_no_more_reads"}, 32'(bus.rd_addr), 32'(rd_at_done));
      check({name, "_no_more_writes"}, 32'(wr_count), 32'(exp_writes));
   endtask

   // Stimulus
   initial begin
      checks    = 0;
      errors    = 0;
      wr_count  = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      load_stream(64'hFFFF_FFFF_FFFF_FFFF);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_state", 32'(fsm_state), 32'(ST_IDLE));
      check("reset_rd_addr", 32'(bus.rd_addr), 32'd0);
      check("reset_wr_addr", 32'(bus.wr_addr), 32'd0);
      check("reset_wr_data", 32'(bus.wr_data), 32'd0);
      check("reset_strobes", 32'({bus.rd_enable, bus.wr_enable}), 32'd0);
      check("reset_done", 32'(bus.done), 32'(1'b0));
      check("reset_error", 32'(bus.error), 32'(1'b0));

      // LITERAL A5 then RUN of 3
      for (int a = 0; a < 4; a++) push_px(a, 8'hA5);
      run_frame("lit_run", 64'hFEA5_C2FF_FFFF_FFFF, 1'b0, 4, 3, 1'b0);

      // DIFF +1, INDEX of empty slot, DIFF -2 wrap, RUN 1; start poked mid-frame
      push_px(0, 8'h25); push_px(1, 8'h00); push_px(2, 8'hDA); push_px(3, 8'hDA);
      run_frame("diff", 64'h7F00_40C0_FFFF_FFFF, 1'b0, 4, 4, 1'b1);

      // LUMA, LITERAL 6D, INDEX hash(6D)=31, INDEX slot 27 (stale from frame 1)
      push_px(0, 8'h25); push_px(1, 8'h6D); push_px(2, 8'h6D); push_px(3, 8'h00);
      run_frame("luma_index", 64'h8588_FE6D_1F1B_FFFF, 1'b0, 4, 6, 1'b0);

      // END after 2 of 4 pixels
      push_px(0, 8'h11); push_px(1, 8'h11);
      run_frame("early_end", 64'hFE11_C0FF_FFFF_FFFF, 1'b1, 2, 4, 1'b0);

      // RUN of 10 with only 3 pixels left
      for (int a = 0; a < 4; a++) push_px(a, 8'h33);
      run_frame("run_trunc", 64'hFE33_C9FF_FFFF_FFFF, 1'b1, 4, 3, 1'b0);

      // Reset in the middle of a RUN
      load_stream(64'hFE5A_C2FF_FFFF_FFFF);
      push_px(0, 8'h5A); push_px(1, 8'h5A);
      wr_count = 0;
      pulse_start();
      for (int i = 0; i < 100 && !(bus.wr_enable === 1'b1 && bus.wr_addr == 1); i++)
         @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_run_wr_enable", 32'(bus.wr_enable), 32'(1'b0));
      check("rst_mid_run_state", 32'(fsm_state), 32'(ST_IDLE));
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_mid_run_writes", 32'(wr_count), 32'd2);
      check("rst_mid_run_pending", 32'(exp_q.size()), 32'd0);
      check("rst_mid_run_idle", 32'({bus.rd_enable, bus.rd_addr}), 32'd0);

      // Fresh frame after reset: chained DIFF +1
      push_px(0, 8'h25); push_px(1, 8'h4A); push_px(2, 8'h6F); push_px(3, 8'h90);
      run_frame("after_rst", 64'h7F7F_7F7F_FFFF_FFFF, 1'b0, 4, 4, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
